// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: config staging, FWFT receive FIFO and error/drop statistics for uart_rx.
// Optional: define UART_RX_CTRL_ERR_DROP_EN to discard errored bytes instead of queueing them.
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   cfg_wr, cfg_*              host strobe and requested framing config (staged)
//   cfg_pending                staged config not yet applied
//   num_data_bits, stop_bits,
//   parity, rx_tx_clk_ratio    live config driven to uart_rx
//   rx_busy, rx_done,
//   rx_data, rx_error          status and received byte from uart_rx
//   rx_full                    back-pressure to uart_rx
//   out_valid, out_data,
//   out_err, out_ready         FIFO head towards the consumer
//   err_count, drop_count      saturating statistics

package uart_rx_pkg;
  typedef enum logic [1:0] {
    STOP_BITS_1   = 2'd0,
    STOP_BITS_1_5 = 2'd1,
    STOP_BITS_2   = 2'd2
  } stop_bits_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;
endpackage

module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_num_data_bits,
  input  stop_bits_t       cfg_stop_bits,
  input  parity_t          cfg_parity,
  input  logic [3:0]       cfg_clk_ratio,
  output logic             cfg_pending,
  output logic [3:0]       num_data_bits,
  output stop_bits_t       stop_bits,
  output parity_t          parity,
  output logic [3:0]       rx_tx_clk_ratio,
  input  logic             rx_busy,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             rx_error,
  output logic             rx_full,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_next;
  end

  // Apply only when uart_rx is idle and not finishing a byte,
  // so a frame never sees two different configs.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (cfg_wr) w_next = S_PEND;
      S_PEND:  if (!rx_busy && !rx_done) w_next = S_APPLY;
      S_APPLY: w_next = cfg_wr ? S_PEND : S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  logic [3:0] w_bits_cl;
  logic [3:0] w_ratio_cl;

  always_comb begin
    w_bits_cl = cfg_num_data_bits;
    if (cfg_num_data_bits < 4'd5)      w_bits_cl = 4'd5;
    else if (cfg_num_data_bits > 4'd8) w_bits_cl = 4'd8;
    w_ratio_cl = (cfg_clk_ratio == 4'd0) ? 4'd1 : cfg_clk_ratio;
  end

  logic [3:0] r_sh_bits;
  logic [3:0] r_sh_ratio;
  stop_bits_t r_sh_stop;
  parity_t    r_sh_par;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh_bits       <= 4'd8;
      r_sh_ratio      <= 4'd8;
      r_sh_stop       <= STOP_BITS_1;
      r_sh_par        <= PARITY_NONE;
      num_data_bits   <= 4'd8;
      rx_tx_clk_ratio <= 4'd8;
      stop_bits       <= STOP_BITS_1;
      parity          <= PARITY_NONE;
      cfg_pending     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        r_sh_bits  <= w_bits_cl;
        r_sh_ratio <= w_ratio_cl;
        r_sh_stop  <= cfg_stop_bits;
        r_sh_par   <= cfg_parity;
      end
      if (r_state == S_APPLY) begin
        num_data_bits   <= r_sh_bits;
        rx_tx_clk_ratio <= r_sh_ratio;
        stop_bits       <= r_sh_stop;
        parity          <= r_sh_par;
      end
      cfg_pending <= (w_next != S_RUN);
    end
  end

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_FULL);

`ifdef UART_RX_CTRL_ERR_DROP_EN
  assign w_push_req = rx_done & ~rx_error;
`else
  assign w_push_req = rx_done;
`endif

  assign w_pop  = ~w_empty & out_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (AW+1)'(1);
    end
  end

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rptr];
  // Hold off uart_rx for the single cycle the config switches.
  assign rx_full   = w_full | (r_state == S_APPLY);

`ifdef UART_RX_CTRL_ERR_DROP_EN
  assign out_err = 1'b0;
`else
  logic [DEPTH-1:0] r_merr;

  always_ff @(posedge clk) begin
    if (!rst)        r_merr <= '0;
    else if (w_push) r_merr[r_wptr] <= rx_error;
  end

  assign out_err = ~w_empty & r_merr[r_rptr];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (rx_done && rx_error && err_count != '1)
        err_count <= err_count + CNT_W'(1);
      if (w_push_req && !w_push && drop_count != '1)
        drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random stimulus for uart_rx_ctrl
// against a queue-based reference of the receive path.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
`ifdef UART_RX_CTRL_ERR_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_wr;
  logic [3:0]       cfg_num_data_bits;
  stop_bits_t       cfg_stop_bits;
  parity_t          cfg_parity;
  logic [3:0]       cfg_clk_ratio;
  logic             cfg_pending;
  logic [3:0]       num_data_bits;
  stop_bits_t       stop_bits;
  parity_t          parity;
  logic [3:0]       rx_tx_clk_ratio;
  logic             rx_busy;
  logic             rx_done;
  logic [7:0]       rx_data;
  logic             rx_error;
  logic             rx_full;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_err;
  logic             out_ready;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] drop_count;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_wr            (cfg_wr),
    .cfg_num_data_bits (cfg_num_data_bits),
    .cfg_stop_bits     (cfg_stop_bits),
    .cfg_parity        (cfg_parity),
    .cfg_clk_ratio     (cfg_clk_ratio),
    .cfg_pending       (cfg_pending),
    .num_data_bits     (num_data_bits),
    .stop_bits         (stop_bits),
    .parity            (parity),
    .rx_tx_clk_ratio   (rx_tx_clk_ratio),
    .rx_busy           (rx_busy),
    .rx_done           (rx_done),
    .rx_data           (rx_data),
    .rx_error          (rx_error),
    .rx_full           (rx_full),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_err           (out_err),
    .out_ready         (out_ready),
    .err_count         (err_count),
    .drop_count        (drop_count)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] q[$];
  int m_err = 0;
  int m_drop = 0;
  int max_cnt = (1 << CNT_W) - 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock with the given receive-side inputs; apl is whether
  // the config switch cycle is expected to be in progress after it.
  task automatic step(input bit done,
                      input logic [7:0] d,
                      input bit e,
                      input bit rdy,
                      input bit apl);
    bit pop;
    bit preq;
    rx_done   = done;
    rx_data   = d;
    rx_error  = e;
    out_ready = rdy;
    @(posedge clk);
    pop  = (q.size() != 0) && rdy;
    preq = done && !(e && DROP_EN);
    if (done && e && m_err < max_cnt) m_err++;
    if (pop) void'(q.pop_front());
    if (preq) begin
      if (q.size() < DEPTH) q.push_back({e, d});
      else if (m_drop < max_cnt) m_drop++;
    end
    #1;
    rx_done = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0][7:0]));
      chk("out_err", 32'(out_err), 32'(q[0][8]));
    end
    chk("rx_full", 32'(rx_full),
        32'((q.size() == DEPTH) || apl));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic set_cfg(input logic [3:0] b,
                         input stop_bits_t s,
                         input parity_t p,
                         input logic [3:0] r);
    cfg_wr            = 1'b1;
    cfg_num_data_bits = b;
    cfg_stop_bits     = s;
    cfg_parity        = p;
    cfg_clk_ratio     = r;
  endtask

  task automatic chk_cfg(input string tag,
                         input int b,
                         input stop_bits_t s,
                         input parity_t p,
                         input int r,
                         input bit pend);
    chk({tag, "_bits"}, 32'(num_data_bits), 32'(b));
    chk({tag, "_stop"}, 32'(stop_bits), 32'(s));
    chk({tag, "_par"}, 32'(parity), 32'(p));
    chk({tag, "_ratio"}, 32'(rx_tx_clk_ratio), 32'(r));
    chk({tag, "_pend"}, 32'(cfg_pending), 32'(pend));
  endtask

  initial begin
    rst               = 1'b0;
    cfg_wr            = 1'b0;
    cfg_num_data_bits = 4'd0;
    cfg_stop_bits     = STOP_BITS_1;
    cfg_parity        = PARITY_NONE;
    cfg_clk_ratio     = 4'd0;
    rx_busy           = 1'b0;
    rx_done           = 1'b0;
    rx_data           = 8'h00;
    rx_error          = 1'b0;
    out_ready         = 1'b0;

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_full", 32'(rx_full), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_dropcnt", 32'(drop_count), 0);
    chk_cfg("rst", 8, STOP_BITS_1, PARITY_NONE, 8, 0);
    rst = 1'b1;

    // single byte latency, then drained
    step(1, 8'hB1, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // overfill: 9 bytes into 8 entries, then drain in order
    for (int i = 0; i <= DEPTH; i++)
      step(1, 8'(i), 0, 0, 0);
    chk("drop_after_overfill", 32'(drop_count), 1);
    for (int i = 0; i <= DEPTH; i++)
      step(0, 8'h00, 0, 1, 0);

    // errored byte
    step(1, 8'h5A, 1, 0, 0);
    chk("err_after_5A", 32'(err_count), 1);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // random traffic: slow consumer first, then fast
    for (int i = 0; i < 400; i++) begin
      bit rdy;
      if (i < 200) rdy = ($urandom_range(0, 3) == 0);
      else         rdy = ($urandom_range(0, 3) != 0);
      step(bit'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 3) == 0), rdy, 0);
    end
    for (int i = 0; i < DEPTH + 1; i++)
      step(0, 8'h00, 0, 1, 0);

    // config staged while a frame is in progress
    rx_busy = 1'b1;
    set_cfg(4'd7, STOP_BITS_1, PARITY_EVEN, 4'd4);
    step(0, 8'h00, 0, 1, 0);
    cfg_wr = 1'b0;
    chk_cfg("busy0", 8, STOP_BITS_1, PARITY_NONE, 8, 1);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    chk_cfg("busy2", 8, STOP_BITS_1, PARITY_NONE, 8, 1);
    rx_busy = 1'b0;
    step(0, 8'h00, 0, 1, 1);
    chk_cfg("apply", 8, STOP_BITS_1, PARITY_NONE, 8, 1);
    step(0, 8'h00, 0, 1, 0);
    chk_cfg("applied", 7, STOP_BITS_1, PARITY_EVEN, 4, 0);

    // last write wins, with clamping
    rx_busy = 1'b1;
    set_cfg(4'd6, STOP_BITS_1, PARITY_EVEN, 4'd3);
    step(0, 8'h00, 0, 1, 0);
    set_cfg(4'd12, STOP_BITS_2, PARITY_ODD, 4'd0);
    step(0, 8'h00, 0, 1, 0);
    cfg_wr  = 1'b0;
    rx_busy = 1'b0;
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 0);
    chk_cfg("lastwr", 8, STOP_BITS_2, PARITY_ODD, 1, 0);

    // pending config held off by a byte completing
    set_cfg(4'd3, STOP_BITS_1, PARITY_NONE, 4'd5);
    step(0, 8'h00, 0, 1, 0);
    cfg_wr = 1'b0;
    step(1, 8'h33, 0, 0, 0);
    chk_cfg("held", 8, STOP_BITS_2, PARITY_ODD, 1, 1);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 0);
    chk_cfg("lowclamp", 5, STOP_BITS_1, PARITY_NONE, 5, 0);

    // new write during the apply cycle
    set_cfg(4'd7, STOP_BITS_1_5, PARITY_NONE, 4'd2);
    step(0, 8'h00, 0, 1, 0);
    cfg_wr = 1'b0;
    step(0, 8'h00, 0, 1, 1);
    set_cfg(4'd6, STOP_BITS_1, PARITY_EVEN, 4'd9);
    step(0, 8'h00, 0, 1, 0);
    cfg_wr = 1'b0;
    chk_cfg("reapply0", 7, STOP_BITS_1_5, PARITY_NONE, 2, 1);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 0);
    chk_cfg("reapply1", 6, STOP_BITS_1, PARITY_EVEN, 9, 0);

    // reset mid-traffic discards FIFO and staged config
    step(1, 8'hC3, 1, 0, 0);
    step(1, 8'h3C, 0, 0, 0);
    rx_busy = 1'b1;
    set_cfg(4'd5, STOP_BITS_2, PARITY_ODD, 4'd3);
    step(0, 8'h00, 0, 0, 0);
    cfg_wr = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx_busy = 1'b0;
    q.delete();
    m_err  = 0;
    m_drop = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_errcnt", 32'(err_count), 0);
    chk_cfg("mid_rst", 8, STOP_BITS_1, PARITY_NONE, 8, 0);
    step(0, 8'h00, 0, 1, 0);
    chk_cfg("no_stale_apply", 8, STOP_BITS_1, PARITY_NONE, 8, 0);
    step(1, 8'h77, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
